// File: rtl/ascon_permutation.sv
// Iterative ASCON permutation core (pc -> ps -> pl), one round per clock.
// Optional build macro ASCON_PERM_UNROLL2_EN chains two rounds per clock.

package ascon_pkg;
  // Word i of the state is element [i]; word 0 is the MSB of each S-box column.
  typedef logic [4:0][63:0] type_state;
endpackage

module constant_addition
  import ascon_pkg::*;
(
  input  type_state   state_i,
  input  logic [3:0]  round_i,
  output type_state   state_o
);

  always_comb begin
    // NOTE: assigning the full output before any partial update keeps this block latch-free.
    state_o    = state_i;
    state_o[2] = state_i[2] ^ {56'b0, 4'hF - round_i, round_i};
  end

endmodule

module ascon_permutation
  import ascon_pkg::*;
#(
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  logic      mode_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_t;

  localparam logic [3:0] FIRST_ROUND_A = 4'(12 - NB_ROUNDS_A);
  localparam logic [3:0] FIRST_ROUND_B = 4'(12 - NB_ROUNDS_B);

`ifdef ASCON_PERM_UNROLL2_EN
  localparam logic [3:0] ROUND_STEP = 4'd2;
  localparam logic [3:0] LAST_ROUND = 4'd10;
`else
  localparam logic [3:0] ROUND_STEP = 4'd1;
  localparam logic [3:0] LAST_ROUND = 4'd11;
`endif

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state sbox_layer(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic type_state linear_layer(input type_state s);
    type_state d;
    d[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
    d[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
    d[2] = s[2] ^ ror(s[2], 1)  ^ ror(s[2], 6);
    d[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
    d[4] = s[4] ^ ror(s[4], 7)  ^ ror(s[4], 41);
    return d;
  endfunction

  fsm_t       fsm_q;
  type_state  state_q;
  logic [3:0] round_q;
  type_state  pc_out0;
  type_state  round_out0;
  type_state  next_state;

  constant_addition u_pc0 (
    .state_i (state_q),
    .round_i (round_q),
    .state_o (pc_out0)
  );

  assign round_out0 = linear_layer(sbox_layer(pc_out0));

`ifdef ASCON_PERM_UNROLL2_EN
  logic [3:0] round_p1;
  type_state  pc_out1;

  assign round_p1 = round_q + 4'd1;

  // Second round of the pair uses the odd index r+1.
  constant_addition u_pc1 (
    .state_i (round_out0),
    .round_i (round_p1),
    .state_o (pc_out1)
  );

  assign next_state = linear_layer(sbox_layer(pc_out1));
`else
  assign next_state = round_out0;
`endif

  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      round_q <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          valid_o <= 1'b0;
          if (start_i) begin
            state_q <= state_i;
            round_q <= mode_i ? FIRST_ROUND_B : FIRST_ROUND_A;
            busy_o  <= 1'b1;
            fsm_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_q <= next_state;
          if (round_q >= LAST_ROUND) begin
            // Counter parks on the last index so 12..15 are never reached.
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
            fsm_q   <= ST_DONE;
          end else begin
            round_q <= round_q + ROUND_STEP;
          end
        end
        ST_DONE: begin
          valid_o <= 1'b0;
          fsm_q   <= ST_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
          fsm_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Self-checking bench for ascon_permutation: table-driven ASCON model, per-cycle compare.
// Build with ASCON_PERM_UNROLL2_EN defined to check the two-rounds-per-cycle variant.

module tb_ascon_permutation;
  import ascon_pkg::*;

`ifdef ASCON_PERM_UNROLL2_EN
  localparam int PER = 2;
`else
  localparam int PER = 1;
`endif

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  logic      clock_i = 1'b0;
  logic      reset_i = 1'b1;
  logic      start_i = 1'b0;
  logic      mode_i  = 1'b0;
  type_state state_i = '0;
  type_state state_o;
  logic      busy_o;
  logic      valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  ascon_permutation dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .state_i (state_i),
    .state_o (state_o),
    .busy_o  (busy_o),
    .valid_o (valid_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] rot_r(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] model_rc(input int r);
    return 64'((15 - r) * 16 + r);
  endfunction

  function automatic type_state model_round(input type_state s, input int r);
    logic [4:0] col, v;
    s[2] = s[2] ^ model_rc(r);
    for (int b = 0; b < 64; b++) begin
      col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      v = SBOX[col];
      s[0][b] = v[4]; s[1][b] = v[3]; s[2][b] = v[2]; s[3][b] = v[1]; s[4][b] = v[0];
    end
    for (int i = 0; i < 5; i++) s[i] = s[i] ^ rot_r(s[i], ROT_A[i]) ^ rot_r(s[i], ROT_B[i]);
    return s;
  endfunction

  function automatic type_state permute(input type_state s, input int r0, input int n);
    for (int i = 0; i < n; i++) s = model_round(s, r0 + i);
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  // Cycle-level expectation: rounds remaining decide busy/valid, not any FSM encoding.
  type_state m_state;
  int        m_rem = 0;
  int        m_r   = 0;
  logic      m_busy, m_valid;

  always @(posedge clock_i) begin
    if (reset_i) begin
      m_state = '0; m_rem = 0; m_busy = 1'b0; m_valid = 1'b0;
    end else if (m_rem > 0) begin
      for (int j = 0; j < PER; j++) begin
        m_state = model_round(m_state, m_r);
        m_r++;
        m_rem--;
      end
      m_busy  = (m_rem > 0);
      m_valid = (m_rem == 0);
    end else if (m_valid) begin
      m_valid = 1'b0;
    end else if (start_i) begin
      m_state = state_i;
      m_rem   = mode_i ? 6 : 12;
      m_r     = 12 - m_rem;
      m_busy  = 1'b1;
    end
  end

  always @(negedge clock_i) begin
    if (chk_en) begin
      check("cyc_state", state_o, m_state);
      check("cyc_busy", busy_o, m_busy);
      check("cyc_valid", valid_o, m_valid);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called #1 after an edge; the start is sampled at the next edge E.
  task automatic run_op(input type_state s, input logic m, input int inject_at,
                        output int busy_cnt, output int valid_at,
                        output type_state first, output type_state result);
    start_i = 1'b1; mode_i = m; state_i = s;
    @(posedge clock_i); #1;
    start_i = 1'b0; state_i = rand_state();
    busy_cnt = 0; valid_at = -1; first = '0; result = '0;
    for (int k = 0; k < 40; k++) begin
      if (valid_o) begin
        valid_at = k;
        result = state_o;
        break;
      end
      if (k == 1) first = state_o;
      busy_cnt += int'(busy_o);
      if (k == inject_at) begin
        start_i = 1'b1; state_i = rand_state(); mode_i = ~m;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clock_i); #1;
    end
    start_i = 1'b0;
  endtask

  task automatic op_check(input string name, input type_state s, input logic m,
                          input int inject_at, output type_state result);
    int n, busy_cnt, valid_at;
    type_state first;
    n = m ? 6 : 12;
    run_op(s, m, inject_at, busy_cnt, valid_at, first, result);
    check({name, "_valid_at"}, valid_at, n / PER);
    check({name, "_busy_cycles"}, busy_cnt, n / PER);
    check({name, "_first_cycle"}, first, permute(s, 12 - n, PER));
    check({name, "_result"}, result, permute(s, 12 - n, n));
  endtask

  type_state tv, zero_round, res_a, res_b;
  int        valid_seen;

  initial begin
    tv = {64'h8899aabbccddeeff, 64'h0011223344556677, 64'h08090a0b0c0d0e0f,
          64'h0001020304050607, 64'h80400c0600000000};
    zero_round = {64'h0, 64'h3C780000000000F0, 64'h3FFFFFFFFFFFFF74,
                  64'h00000001E0000770, 64'h001E0F00000000F0};

    // Hand-derived pins on the model itself.
    check("pin_rc0", model_rc(0), 64'hF0);
    check("pin_rc6", model_rc(6), 64'h96);
    check("pin_rc11", model_rc(11), 64'h4B);
    check("pin_zero_round0", model_round('0, 0), zero_round);

    // Reset held with start asserted: nothing may be accepted.
    reset_i = 1'b1; start_i = 1'b1; state_i = tv; mode_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock_i); #1;
      chk_en = 1'b1;
      check("reset_state", state_o, '0);
      check("reset_busy", busy_o, 1'b0);
      check("reset_valid", valid_o, 1'b0);
    end
    reset_i = 1'b0; start_i = 1'b0;
    @(posedge clock_i); #1;
    check("post_reset_idle_busy", busy_o, 1'b0);

    // Zero state: first RUN cycle against the hand-computed round-0 value.
    op_check("zero_pa", '0, 1'b0, -1, res_a);
`ifndef ASCON_PERM_UNROLL2_EN
    begin
      int bc, va;
      type_state f, r;
      @(posedge clock_i); #1;
      run_op('0, 1'b0, -1, bc, va, f, r);
      check("zero_round0_literal", f, zero_round);
    end
`endif

    // Reference vector, pa and pb.
    @(posedge clock_i); #1;
    op_check("tv_pa", tv, 1'b0, -1, res_a);
    @(posedge clock_i); #1;
    op_check("tv_pb", tv, 1'b1, -1, res_b);

    // Start while busy is ignored.
    @(posedge clock_i); #1;
    op_check("tv_pa_inject", tv, 1'b0, 3, res_b);
    check("inject_same_result", res_b, res_a);

    // Mid-run reset: partial state dropped, no valid afterwards.
    @(posedge clock_i); #1;
    start_i = 1'b1; mode_i = 1'b0; state_i = tv;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    repeat (4) begin
      @(posedge clock_i); #1;
    end
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    check("midreset_state", state_o, '0);
    check("midreset_busy", busy_o, 1'b0);
    check("midreset_valid", valid_o, 1'b0);
    valid_seen = 0;
    repeat (16) begin
      @(posedge clock_i); #1;
      valid_seen += int'(valid_o);
    end
    check("midreset_no_valid", valid_seen, 0);
    op_check("after_reset_pa", tv, 1'b0, -1, res_a);

    // Back-to-back: start pulsed in DONE is ignored, pb accepted in the next cycle.
    @(posedge clock_i); #1;
    op_check("b2b_pa", tv, 1'b0, -1, res_a);
    start_i = 1'b1; state_i = rand_state(); mode_i = 1'b1;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    check("b2b_hold_idle", state_o, permute(tv, 0, 12));
    check("b2b_idle_busy", busy_o, 1'b0);
    op_check("b2b_pb", tv ^ {5{64'h5a5a}}, 1'b1, -1, res_b);
    check("b2b_pb_hold", state_o, permute(tv ^ {5{64'h5a5a}}, 6, 6));

    // Randomised operations with random gaps.
    for (int t = 0; t < 8; t++) begin
      type_state rs;
      rs = rand_state();
      repeat ($urandom_range(1, 3)) begin
        @(posedge clock_i); #1;
      end
      op_check("rand_op", rs, 1'($urandom_range(0, 1)), -1, res_a);
    end

    repeat (3) begin
      @(posedge clock_i); #1;
    end
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
